// File: rtl/kairo_muldiv_pkg.sv
// kairo_muldiv_pkg
//   Shared types and helpers for the RV32M multiply/divide sequencer.
//   - md_state_t : sequencer states (IDLE, MUL, DIV, FIX, DONE)
//   - md_op_t    : 3-bit encoding of the eight M-extension operations
//   - decode_op  : priority-encodes the decoder's one-hot op flags
package kairo_muldiv_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } md_state_t;

  typedef enum logic [2:0] {
    OP_MUL,
    OP_MULH,
    OP_MULHSU,
    OP_MULHU,
    OP_DIV,
    OP_DIVU,
    OP_REM,
    OP_REMU
  } md_op_t;

  // flags[7] = MUL ... flags[0] = REMU. Flags should be one-hot; if several
  // are set the earliest in RV32M order wins.
  function automatic md_op_t decode_op(input logic [7:0] flags);
    md_op_t op;
    if      (flags[7]) op = OP_MUL;
    else if (flags[6]) op = OP_MULH;
    else if (flags[5]) op = OP_MULHSU;
    else if (flags[4]) op = OP_MULHU;
    else if (flags[3]) op = OP_DIV;
    else if (flags[2]) op = OP_DIVU;
    else if (flags[1]) op = OP_REM;
    else               op = OP_REMU;
    return op;
  endfunction

  function automatic logic is_mul_op(input md_op_t op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
  endfunction

  function automatic logic is_signed_div(input md_op_t op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/kairo_muldiv_ctrl_div_step.sv
// kairo_muldiv_ctrl_div_step
//   One iteration of a radix-2 restoring divide (purely combinational).
//   Shifts the next dividend bit (MSB of quo_i) into the partial remainder,
//   trial-subtracts the divisor and shifts the resulting quotient bit into quo_o.
// Ports
//   rem_i     [XLEN:0]   partial remainder in
//   quo_i     [XLEN-1:0] remaining dividend bits / quotient bits so far
//   divisor_i [XLEN-1:0] divisor magnitude
//   rem_o     [XLEN:0]   partial remainder out
//   quo_o     [XLEN-1:0] shifted quotient with the new bit in the LSB
module kairo_div_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN:0]   rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN:0]   rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN+1:0] shifted;
  logic [XLEN+1:0] diff;
  logic            fits;

  // One guard bit above the partial remainder lets the MSB of diff act as
  // the borrow of the trial subtraction.
  assign shifted = {rem_i, quo_i[XLEN-1]};
  assign diff    = shifted - {2'b00, divisor_i};
  assign fits    = ~diff[XLEN+1];

  assign rem_o = fits ? diff[XLEN:0] : shifted[XLEN:0];
  assign quo_o = {quo_i[XLEN-2:0], fits};

endmodule

// File: rtl/kairo_muldiv_ctrl.sv
// kairo_muldiv_ctrl
//   Sequencer for RV32M operations. Captures operands when an M op is
//   issued, runs a pipelined multiply or a bit-serial restoring divide, and
//   returns the result with a one-cycle ready pulse. Holds the execute stage
//   via stall_o while an op is in flight; kill_i aborts on a pipeline flush.
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start_i               issue strobe, only sampled while idle
//   inst_*_i              one-hot op flags from the decoder
//   rs1_i, rs2_i          dividend/multiplicand, divisor/multiplier
//   kill_i                abort the current op
//   stall_o               pipeline hold request
//   ready_o               one-cycle result-valid pulse
//   result_o              result, held until the next accepted op completes
module kairo_muldiv_ctrl
  import kairo_muldiv_pkg::*;
#(
  parameter int unsigned XLEN       = XLEN_DEFAULT,
  parameter int unsigned MUL_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            inst_mul_i,
  input  logic            inst_mulh_i,
  input  logic            inst_mulhsu_i,
  input  logic            inst_mulhu_i,
  input  logic            inst_div_i,
  input  logic            inst_divu_i,
  input  logic            inst_rem_i,
  input  logic            inst_remu_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            kill_i,
  output logic            stall_o,
  output logic            ready_o,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned CNT_MAX = (XLEN > MUL_CYCLES) ? XLEN : MUL_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  // State and datapath registers. quo_q/dvsr_q double as the raw multiply
  // operands; for divides they hold dividend/quotient and divisor magnitude.
  md_state_t       state_q, state_d;
  md_op_t          op_q, op_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN:0]   rem_q, rem_d;
  logic [XLEN-1:0] dvsr_q, dvsr_d;
  logic            negq_q, negq_d;
  logic            negr_q, negr_d;
  logic [XLEN-1:0] result_q, result_d;

  logic [7:0]      op_flags;
  md_op_t          new_op;
  logic            accept;
  logic            new_sgn;
  logic [XLEN-1:0] rs1_mag, rs2_mag;
  logic [XLEN:0]   step_rem;
  logic [XLEN-1:0] step_quo;
  logic [XLEN-1:0] done_val;

  assign op_flags = {inst_mul_i, inst_mulh_i, inst_mulhsu_i, inst_mulhu_i,
                     inst_div_i, inst_divu_i, inst_rem_i, inst_remu_i};
  assign new_op   = decode_op(op_flags);
  assign accept   = start_i && (state_q == ST_IDLE) && (|op_flags) && !kill_i;

  assign new_sgn  = is_signed_div(new_op);
  assign rs1_mag  = (new_sgn && rs1_i[XLEN-1]) ? -rs1_i : rs1_i;
  assign rs2_mag  = (new_sgn && rs2_i[XLEN-1]) ? -rs2_i : rs2_i;

  // --------------------------------------------------------------------
  // Multiplier: both operands extended to 2*XLEN per op signedness; the
  // 2*XLEN-bit wrap-around product of sign-extended values equals the exact
  // signed product. MUL_CYCLES-1 register stages follow for retiming.
  // --------------------------------------------------------------------
  logic            mul_a_sgn, mul_b_sgn;
  logic [2*XLEN-1:0] mul_a, mul_b, prod_c, prod_out;

  assign mul_a_sgn = (op_q == OP_MULH) || (op_q == OP_MULHSU);
  assign mul_b_sgn = (op_q == OP_MULH);
  assign mul_a     = {{XLEN{mul_a_sgn & quo_q[XLEN-1]}}, quo_q};
  assign mul_b     = {{XLEN{mul_b_sgn & dvsr_q[XLEN-1]}}, dvsr_q};
  assign prod_c    = mul_a * mul_b;

  if (MUL_CYCLES == 1) begin : g_no_pipe
    assign prod_out = prod_c;
  end else begin : g_pipe
    logic [2*XLEN-1:0] pipe_q [MUL_CYCLES-1];

    // NOTE: small pipeline registers are reset like all other state so the
    // block is fully deterministic out of reset; large memories would not be.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < MUL_CYCLES - 1; i++) pipe_q[i] <= '0;
      end else begin
        pipe_q[0] <= prod_c;
        for (int i = 1; i < MUL_CYCLES - 1; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end

    assign prod_out = pipe_q[MUL_CYCLES-2];
  end

  // --------------------------------------------------------------------
  // Divider iteration
  // --------------------------------------------------------------------
  kairo_div_step #(.XLEN(XLEN)) u_div_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvsr_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  // Value presented during DONE; also latched into result_q on the way out.
  always_comb begin
    done_val = quo_q;
    case (op_q)
      OP_MUL:                        done_val = prod_out[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  done_val = prod_out[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               done_val = quo_q;
      default:                       done_val = rem_q[XLEN-1:0];
    endcase
  end

  // --------------------------------------------------------------------
  // Next-state and datapath
  // --------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvsr_d   = dvsr_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    result_d = result_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d = new_op;
          if (is_mul_op(new_op)) begin
            quo_d   = rs1_i;
            dvsr_d  = rs2_i;
            rem_d   = '0;
            negq_d  = 1'b0;
            negr_d  = 1'b0;
            cnt_d   = CW'(MUL_CYCLES - 1);
            state_d = (MUL_CYCLES == 1) ? ST_DONE : ST_MUL;
          end else if (rs2_i == '0) begin
            // Divide by zero: quotient all-ones, remainder is the dividend.
            quo_d   = '1;
            rem_d   = {1'b0, rs1_i};
            negq_d  = 1'b0;
            negr_d  = 1'b0;
            state_d = ST_DONE;
          end else if (new_sgn && (rs1_i == INT_MIN) && (rs2_i == '1)) begin
            // Signed overflow: quotient wraps to INT_MIN, remainder zero.
            quo_d   = INT_MIN;
            rem_d   = '0;
            negq_d  = 1'b0;
            negr_d  = 1'b0;
            state_d = ST_DONE;
          end else begin
            quo_d   = rs1_mag;
            dvsr_d  = rs2_mag;
            rem_d   = '0;
            negq_d  = new_sgn && (rs1_i[XLEN-1] ^ rs2_i[XLEN-1]);
            negr_d  = new_sgn && rs1_i[XLEN-1];
            cnt_d   = CW'(XLEN);
            state_d = ST_DIV;
          end
        end
      end

      ST_MUL: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = ST_DONE;
      end

      ST_DIV: begin
        quo_d = step_quo;
        rem_d = step_rem;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = ST_FIX;
      end

      ST_FIX: begin
        if (negq_q) quo_d = -quo_q;
        if (negr_q) rem_d = {1'b0, -rem_q[XLEN-1:0]};
        state_d = ST_DONE;
      end

      ST_DONE: begin
        result_d = done_val;
        state_d  = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // A flush wins over any sequencing; DONE still retires its result.
    if (kill_i) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MUL;
      cnt_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvsr_q   <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      result_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvsr_q   <= dvsr_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      result_q <= result_d;
    end
  end

  // --------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------
  assign stall_o  = accept || ((state_q != ST_IDLE) && (state_q != ST_DONE));
  assign ready_o  = (state_q == ST_DONE);
  assign result_o = ready_o ? done_val : result_q;

endmodule

// File: tb/tb_kairo_muldiv_ctrl.sv
// tb_kairo_muldiv_ctrl
//   Directed self-checking bench. A behavioural model predicts result value
//   and completion cycle of each accepted op from the RV32M rules; one
//   compare process checks ready/stall/result every cycle against it.
module tb_kairo_muldiv_ctrl;

  localparam int MULC = 2;
  localparam int OPC_MUL = 0, OPC_MULH = 1, OPC_MULHSU = 2, OPC_MULHU = 3;
  localparam int OPC_DIV = 4, OPC_DIVU = 5, OPC_REM = 6, OPC_REMU = 7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic        kill_i = 1'b0;
  logic [7:0]  flags = 8'h00;
  logic [31:0] rs1_i = '0;
  logic [31:0] rs2_i = '0;
  logic        stall_o, ready_o;
  logic [31:0] result_o;

  always #5 clk = ~clk;

  kairo_muldiv_ctrl #(.XLEN(32), .MUL_CYCLES(MULC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start_i),
    .inst_mul_i    (flags[7]),
    .inst_mulh_i   (flags[6]),
    .inst_mulhsu_i (flags[5]),
    .inst_mulhu_i  (flags[4]),
    .inst_div_i    (flags[3]),
    .inst_divu_i   (flags[2]),
    .inst_rem_i    (flags[1]),
    .inst_remu_i   (flags[0]),
    .rs1_i         (rs1_i),
    .rs2_i         (rs2_i),
    .kill_i        (kill_i),
    .stall_o       (stall_o),
    .ready_o       (ready_o),
    .result_o      (result_o)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Model state
  bit          m_active  = 1'b0;
  int          m_done    = 0;
  logic [31:0] m_result  = '0;
  logic [31:0] m_pending = '0;
  int          s_cyc     = 0;
  int          last_ready = -1;
  int          ready_count = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model_result(input int op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] pu, ps;
    longint      sa, sb, ub;
    bit          ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ub  = longint'({32'h0, b});
    pu  = {32'h0, a} * {32'h0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      OPC_MUL:    return pu[31:0];
      OPC_MULH:   begin ps = sa * sb; return ps[63:32]; end
      OPC_MULHSU: begin ps = sa * ub; return ps[63:32]; end
      OPC_MULHU:  return pu[63:32];
      OPC_DIV:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
      OPC_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OPC_REM:    return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      default:    return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_latency(input int op, input logic [31:0] a, input logic [31:0] b);
    if (op < OPC_DIV) return MULC;
    if (b == 0) return 1;
    if ((op == OPC_DIV || op == OPC_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 32 + 2;
  endfunction

  function automatic int flag_to_op(input logic [7:0] f);
    for (int i = 7; i >= 0; i--) if (f[i]) return 7 - i;
    return -1;
  endfunction

  // Compare process: checked on every falling edge.
  always @(negedge clk) begin
    bit          exp_ready, exp_stall;
    logic [31:0] exp_res;
    if (!rst_n) begin
      check("rst_ready", {31'h0, ready_o}, 32'h0);
      check("rst_stall", {31'h0, stall_o}, 32'h0);
      check("rst_result", result_o, 32'h0);
      m_active = 1'b0;
      m_result = '0;
    end else begin
      exp_ready = m_active && (cyc == m_done);
      exp_stall = m_active && (cyc < m_done);
      exp_res   = exp_ready ? m_pending : m_result;
      check("ready", {31'h0, ready_o}, {31'h0, exp_ready});
      check("stall", {31'h0, stall_o}, {31'h0, exp_stall});
      check("result", result_o, exp_res);
      if (ready_o) begin
        last_ready = cyc;
        ready_count++;
      end
      if (exp_ready) begin
        m_result = m_pending;
        m_active = 1'b0;
      end else if (kill_i && m_active) begin
        m_active = 1'b0;
      end
    end
  end

  // Drive one start cycle; the model decides whether it is accepted.
  task automatic drive_start(input logic [7:0] f, input logic [31:0] a, input logic [31:0] b,
                             input bit k);
    int op;
    @(posedge clk); #1;
    flags   = f;
    rs1_i   = a;
    rs2_i   = b;
    start_i = 1'b1;
    kill_i  = k;
    op      = flag_to_op(f);
    if (m_active) begin
      $display("[TB] note: START while busy at cycle %0d (protocol error, must be ignored)", cyc);
    end else if (op >= 0 && !k) begin
      m_active  = 1'b1;
      s_cyc     = cyc;
      m_done    = cyc + model_latency(op, a, b);
      m_pending = model_result(op, a, b);
    end
    @(posedge clk); #1;
    start_i = 1'b0;
    kill_i  = 1'b0;
    flags   = 8'h00;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!m_active) break;
      @(posedge clk);
    end
    check("done_within_budget", {31'h0, m_active}, 32'h0);
    @(posedge clk); #1;
  endtask

  task automatic run_op(input string name, input int op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_lat);
    int rc0;
    rc0 = ready_count;
    drive_start(8'h80 >> op, a, b, 1'b0);
    wait_done(80);
    check({name, "_res"}, result_o, exp_res);
    check({name, "_lat"}, 32'(last_ready - s_cyc), 32'(exp_lat));
    check({name, "_pulses"}, 32'(ready_count - rc0), 32'd1);
  endtask

  initial begin
    int rc0;

    // Model pins against hand-computed values
    check("pin_mul",    model_result(OPC_MUL,    32'd7,          32'hFFFF_FFFD), 32'hFFFF_FFEB);
    check("pin_mulhu",  model_result(OPC_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF), 32'hFFFF_FFFE);
    check("pin_mulhsu", model_result(OPC_MULHSU, 32'hFFFF_FFFF,  32'd2),         32'hFFFF_FFFF);
    check("pin_mulh",   model_result(OPC_MULH,   32'h8000_0000,  32'h8000_0000), 32'h4000_0000);
    check("pin_div",    model_result(OPC_DIV,    32'hFFFF_FFF9,  32'd2),         32'hFFFF_FFFD);
    check("pin_rem",    model_result(OPC_REM,    32'hFFFF_FFF9,  32'd2),         32'hFFFF_FFFF);
    check("pin_lat_div", 32'(model_latency(OPC_DIV, 32'd9, 32'd2)), 32'd34);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Multiply family
    run_op("mul",    OPC_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 2);
    run_op("mulhu",  OPC_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);
    run_op("mulhsu", OPC_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 2);
    run_op("mulh",   OPC_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2);
    run_op("mulhsu2",OPC_MULHSU, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 2);
    run_op("mulh2",  OPC_MULH,   32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 2);

    // Divide family
    run_op("div",    OPC_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34);
    run_op("rem",    OPC_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34);
    run_op("div2",   OPC_DIV,    32'd20,        32'hFFFF_FFFD, 32'hFFFF_FFFA, 34);
    run_op("rem2",   OPC_REM,    32'd20,        32'hFFFF_FFFD, 32'd2,         34);
    run_op("divu",   OPC_DIVU,   32'hFFFF_FFFF, 32'd3,         32'h5555_5555, 34);
    run_op("remu",   OPC_REMU,   32'd100,       32'd7,         32'd2,         34);

    // Special cases
    run_op("divu0",  OPC_DIVU,   32'd100,       32'd0,         32'hFFFF_FFFF, 1);
    run_op("remu0",  OPC_REMU,   32'd100,       32'd0,         32'd100,       1);
    run_op("divovf", OPC_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("removf", OPC_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1);
    run_op("div0",   OPC_DIV,   32'hFFFF_FFF0,  32'd0,         32'hFFFF_FFFF, 1);

    // Priority on non-one-hot flags: MUL wins over DIV
    rc0 = ready_count;
    drive_start(8'h88, 32'd6, 32'd7, 1'b0);
    wait_done(80);
    check("prio_res", result_o, 32'd42);
    check("prio_pulses", 32'(ready_count - rc0), 32'd1);

    // START without a flag and START together with KILL are both ignored
    rc0 = ready_count;
    drive_start(8'h00, 32'd1, 32'd1, 1'b0);
    drive_start(8'h80 >> OPC_MUL, 32'd3, 32'd3, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check("ignored_pulses", 32'(ready_count - rc0), 32'd0);
    check("ignored_result", result_o, 32'd42);

    // KILL at cycle 10 of a divide
    rc0 = ready_count;
    drive_start(8'h80 >> OPC_DIV, 32'd1000, 32'd10, 1'b0);
    repeat (9) @(posedge clk);
    #1 kill_i = 1'b1;
    @(posedge clk);
    #1 kill_i = 1'b0;
    check("kill_stall_after", {31'h0, stall_o}, 32'h0);
    repeat (40) @(posedge clk);
    #1;
    check("kill_pulses", 32'(ready_count - rc0), 32'd0);
    check("kill_result", result_o, 32'd42);
    run_op("after_kill", OPC_DIVU, 32'd1000, 32'd10, 32'd100, 34);

    // START while busy is ignored: exactly one ready pulse
    rc0 = ready_count;
    drive_start(8'h80 >> OPC_REMU, 32'd17, 32'd5, 1'b0);
    repeat (2) @(posedge clk);
    drive_start(8'h80 >> OPC_MUL, 32'd9, 32'd9, 1'b0);
    wait_done(80);
    repeat (4) @(posedge clk);
    #1;
    check("busy_res", result_o, 32'd2);
    check("busy_pulses", 32'(ready_count - rc0), 32'd1);

    // Reset at cycle 5 of a divide
    rc0 = ready_count;
    drive_start(8'h80 >> OPC_DIV, 32'd81, 32'd9, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #2;
    check("midrst_ready", {31'h0, ready_o}, 32'h0);
    check("midrst_result", result_o, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("midrst_pulses", 32'(ready_count - rc0), 32'd0);
    run_op("after_rst", OPC_MUL, 32'd12, 32'd12, 32'd144, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
